// File: rtl/display_pkg.sv
// Shared widths, FSM state type and active-high segment patterns for test_value_display.
package display_pkg;

  localparam int VALUE_W = 16;
  localparam int DIGITS  = 5;
  localparam int BCD_W   = 20;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_t;

  // Bit order {g,f,e,d,c,b,a}, 1 = segment lit.
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] acc);
    logic [BCD_W-1:0] res;
    res = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD nibble to active-high seven-segment pattern; 10-15 decode to blank.
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    case (nibble)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/test_value_display.sv
// Test_Value to 5-digit multiplexed seven-segment display: sequential double-dabble plus scan.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero digit.
//
// state | meaning
// IDLE  | waiting for value_in to differ from last_value
// SHIFT | 16 add-3/shift iterations of double-dabble
// LATCH | copy acc to bcd_out, pulse done
module test_value_display
  import display_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [VALUE_W-1:0] value_in,
  output logic [BCD_W-1:0]   bcd_out,
  output logic               busy,
  output logic               done,
  output logic [DIGITS-1:0]  an,
  output logic [6:0]         seg,
  output logic               dp
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

  state_t             state_q, state_d;
  logic [VALUE_W-1:0] shift_q, shift_d;
  logic [VALUE_W-1:0] last_q, last_d;
  logic [BCD_W-1:0]   acc_q, acc_d, acc_adj;
  logic [3:0]         cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_d;
  logic               busy_d, done_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      last_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_out <= bcd_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  assign acc_adj = dabble_adjust(acc_q);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    last_d  = last_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_out;
    busy_d  = busy;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (value_in != last_q) begin
          shift_d = value_in;
          last_d  = value_in;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          busy_d = 1'b0;
        end
      end
      SHIFT: begin
        {acc_d, shift_d} = {acc_adj, shift_q} << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        bcd_d   = acc_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic [CNT_W-1:0] refresh_cnt;
  logic [2:0]       digit_idx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == CNT_LAST) begin
      refresh_cnt <= '0;
      digit_idx   <= (digit_idx == 3'd4) ? 3'd0 : digit_idx + 3'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  logic [4:0] nib_lsb;
  logic [3:0] nibble;
  logic [6:0] pattern, seg_lit, seg_next;
  logic       blank;

  assign nib_lsb = {digit_idx, 2'b00};
  assign nibble  = 4'(bcd_out >> nib_lsb);

  seg7_decoder u_seg7_decoder (
    .nibble  (nibble),
    .pattern (pattern)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Digit0 is never blanked so a zero value still shows a single "0".
  assign blank = (digit_idx != 3'd0) && ((bcd_out >> nib_lsb) == '0);
`else
  assign blank = 1'b0;
`endif

  assign seg_lit  = blank ? SEG_BLANK : pattern;
  assign seg_next = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;

  // Registered outputs lag digit_idx/bcd_out by one cycle, so the new bcd_out
  // appears cleanly on the edge after LATCH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      an  <= '1;
      seg <= SEG_OFF;
      dp  <= DP_OFF;
    end else begin
      an  <= ~(5'b00001 << digit_idx);
      seg <= seg_next;
      dp  <= DP_OFF;
    end
  end

endmodule
